tdm_mux_scan: RTL
=================

Name: tdm_mux_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer that generalises the fixed 8:1 single-bit mux tree to arbitrary width and channel count.
- Two modes:
  - Fixed: the channel is chosen by `sel_in`.
  - Scan: round-robin time-division over the enabled channels, skipping disabled ones.
- Output uses a valid/ready handshake with backpressure.
- Sits between parallel sensor/data sources and a single serial consumer (UART framer, FIFO).

Parameters:
- WIDTH, 8, bit width of each channel.
- CHANNELS, 8, number of input channels; must be ≥2.
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived; not overridden).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  packed channels; channel k is data_in[k*WIDTH +: WIDTH].
- chan_en  in  CHANNELS  per-channel enable mask; used in scan mode.
- mode  in  1  0 = FIXED, 1 = SCAN.
- sel_in  in  SEL_W  channel index for FIXED mode.
- run  in  1  level; while high the block produces samples.
- out_data  out  WIDTH  registered sample.
- out_chan  out  SEL_W  channel index of out_data.
- out_valid  out  1  sample valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- sel_err  out  1  one-cycle pulse; FIXED mode with sel_in ≥ CHANNELS.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - out_data=0, out_chan=0, out_valid=0, sel_err=0.
  - Scan pointer ptr=0.
  - Reset asserted mid-transfer drops out_valid the next cycle; the pending sample is discarded.
- States:
  - IDLE:
    - out_valid=0.
    - If run=1, go to LOAD.
  - LOAD, one-cycle sample capture:
    - FIXED mode:
      - sel_in < CHANNELS: capture data_in[sel_in], out_chan=sel_in, out_valid=1, go to HOLD.
      - sel_in ≥ CHANNELS: out_data=0, out_valid stays 0, pulse sel_err, stay in LOAD (retries every cycle).
    - SCAN mode:
      - Find the first enabled channel at or after ptr, wrapping modulo CHANNELS.
      - Capture it, out_chan=that index, out_valid=1.
      - ptr = index+1 with wrap (CHANNELS-1 → 0).
      - Go to HOLD.
      - If chan_en == 0: no capture, out_valid=0, ptr unchanged, stay in LOAD.
  - HOLD:
    - out_data and out_chan are stable while out_valid && !out_ready; the input channels are not re-sampled.
    - On handshake (out_ready=1):
      - run=1: go to LOAD; out_valid drops for exactly one cycle.
      - run=0: go to IDLE.
- Throughput: one sample per 2 cycles at most; latency from the LOAD edge to out_valid is 1 cycle.
- run falling while in HOLD:
  - The current sample is still delivered.
  - IDLE is entered only after the handshake.
- Changes while in HOLD:
  - mode, sel_in and chan_en changes have no effect until the next LOAD.
- Simultaneous events:
  - rst has priority over everything.
  - A handshake and run=0 in the same cycle go to IDLE.
- ptr holds its value across IDLE, so scan resumes where it stopped; only rst clears it.
- CHANNELS not a power of 2:
  - ptr wraps at CHANNELS-1.
  - Unused select codes raise sel_err in FIXED mode.

Decomposition:
- Package tdm_mux_pkg holds:
  - Mode constants MODE_FIXED=1'b0, MODE_SCAN=1'b1.
  - State enum {IDLE, LOAD, HOLD}.
- Sub-module mux_nto1 (params WIDTH, CHANNELS): purely combinational N:1 selector from the packed bus.
  - Returns 0 for an out-of-range select, matching the default-zero behaviour of the existing muxes.
  - Used by LOAD.
- Priority search for the next enabled channel (rotate-by-ptr + priority encoder) is a function inside tdm_mux_scan.

Test Plan (WIDTH=8, CHANNELS=8; channel k holds 8'h10+k):
1. Reset: hold rst for 2 cycles with run=1 → out_valid=0, out_data=0, out_chan=0, sel_err=0. First sample appears 2 cycles after rst deasserts.
2. FIXED mode, sel_in=5, out_ready=1 → samples 8'h15 / chan 5, one every 2 cycles. Change sel_in to 2 during HOLD → the next sample is 8'h12.
3. SCAN mode, chan_en=8'b1010_0101, out_ready=1 → out_chan sequence 0,2,5,7,0,2…; data 8'h10, 8'h12, 8'h15, 8'h17.
4. Backpressure: out_ready=0 for 5 cycles on sample chan 2 → out_data=8'h12 stable with out_valid=1 the whole time. After out_ready=1, the next sample is chan 5.
5. Boundaries, each checked separately:
   - chan_en=0 in SCAN → out_valid stays 0.
   - CHANNELS=6 in FIXED with sel_in=7 → sel_err pulses each cycle, out_valid=0.
   - SCAN with only chan 5 enabled → ptr wraps 6 → 5 repeatedly, with no stall.
6. Mid-operation events:
   - rst asserted during HOLD → out_valid=0 next cycle; ptr back to 0, so the first scan sample after reset is chan 0.
   - run=0 during HOLD → the pending sample completes its handshake, then the block goes to IDLE.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// tdm_mux_scan shared types.
// Mode codes and the FSM state encoding.
package tdm_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_e;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 selector over a packed bus.
// Out-of-range selects yield zero.
module mux_nto1 #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WIDTH-1:0]          o_data
);

  // pick channel i_sel, zero when no channel matches
  always_comb begin
    o_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/tdm_mux_scan.sv
// Registered N-channel mux: fixed select or round-robin
// scan over enabled channels, valid/ready output.
module tdm_mux_scan
  import tdm_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      run,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  // Rotate the enable mask so ptr sits at bit 0, then take
  // the lowest set bit; result is {hit, absolute index}.
  function automatic logic [SEL_W:0] find_next(
    input logic [CHANNELS-1:0] en,
    input logic [SEL_W-1:0]    p
  );
    logic [SEL_W:0] res;
    int             idx;
    res = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (en[SEL_W'(idx)]) begin
        res = {1'b1, SEL_W'(idx)};
      end
    end
    return res;
  endfunction

  state_e           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic             r_sel_err;

  logic [SEL_W:0]   w_scan;
  logic             w_scan_hit;
  logic [SEL_W-1:0] w_scan_idx;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic             w_sel_ok;
  logic [SEL_W-1:0] w_mux_sel;
  logic [WIDTH-1:0] w_mux_data;

  assign w_scan     = find_next(chan_en, r_ptr);
  assign w_scan_hit = w_scan[SEL_W];
  assign w_scan_idx = w_scan[SEL_W-1:0];

  assign w_ptr_nxt =
    (w_scan_idx == SEL_W'(CHANNELS - 1)) ?
    '0 : w_scan_idx + SEL_W'(1);

  assign w_sel_ok =
    ({1'b0, sel_in} < (SEL_W+1)'(CHANNELS));

  assign w_mux_sel =
    (mode == MODE_SCAN) ? w_scan_idx : sel_in;

  mux_nto1 #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_mux (
    .i_data (data_in),
    .i_sel  (w_mux_sel),
    .o_data (w_mux_data)
  );

  // Control FSM with registered sample, channel and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sel_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (run) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (mode == MODE_FIXED) begin
            if (w_sel_ok) begin
              r_out_data  <= w_mux_data;
              r_out_chan  <= sel_in;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_out_data  <= '0;
              r_out_valid <= 1'b0;
              r_sel_err   <= 1'b1;
            end
          end else if (w_scan_hit) begin
            r_out_data  <= w_mux_data;
            r_out_chan  <= w_scan_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= w_ptr_nxt;
            r_state     <= HOLD;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= run ? LOAD : IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule
